// File: rtl/multiword_csa_sequencer_pkg.sv
// Shared constants for the multi-limb carry-select add/sub sequencer.
// Limb width is tied to the 64-bit CSA core; FSM encoding kept as plain constants.
package multiword_csa_sequencer_pkg;

    localparam int WORD_W        = 64;
    localparam int MAX_LIMBS_DEF = 16;
    localparam int CSA_BLK_W     = 16;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Two's-complement overflow of a + b_eff given the MSBs of operands and sum.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/multiword_csa_sequencer_csa.sv
// 64-bit carry-select adder: each 16-bit block precomputes both carry-in cases
// and the rippling block carry only drives the selects.
module SixtyFourBitCSA_Standard
    import multiword_csa_sequencer_pkg::*;
(
    input  logic [WORD_W-1:0] A,
    input  logic [WORD_W-1:0] B,
    input  logic              C0,
    output logic [WORD_W-1:0] S,
    output logic              C_Out
);

    localparam int NBLK = WORD_W / CSA_BLK_W;

    logic [NBLK:0] blk_c;

    assign blk_c[0] = C0;

    for (genvar g = 0; g < NBLK; g++) begin : g_blk
        logic [CSA_BLK_W:0] sum0, sum1;

        assign sum0 = {1'b0, A[g*CSA_BLK_W +: CSA_BLK_W]} + {1'b0, B[g*CSA_BLK_W +: CSA_BLK_W]};
        assign sum1 = sum0 + {{CSA_BLK_W{1'b0}}, 1'b1};

        assign S[g*CSA_BLK_W +: CSA_BLK_W] = blk_c[g] ? sum1[CSA_BLK_W-1:0] : sum0[CSA_BLK_W-1:0];
        assign blk_c[g+1] = blk_c[g] ? sum1[CSA_BLK_W] : sum0[CSA_BLK_W];
    end

    assign C_Out = blk_c[NBLK];

endmodule

// File: rtl/multiword_csa_sequencer.sv
// Streams N x 64-bit add/sub limbs through one CSA core, chaining the carry
// across cycles and presenting each result limb behind a valid/ready register.
module multiword_csa_sequencer
    import multiword_csa_sequencer_pkg::*;
#(
    parameter  int MAX_LIMBS = MAX_LIMBS_DEF,
    localparam int IDX_W     = (MAX_LIMBS > 1) ? $clog2(MAX_LIMBS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic              In_First,
    input  logic              In_Last,
    input  logic              Sub,
    input  logic              Cin,
    input  logic [WORD_W-1:0] A,
    input  logic [WORD_W-1:0] B,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [WORD_W-1:0] S,
    output logic              Out_Last,
    output logic [IDX_W-1:0]  Out_Index,
    output logic              C_Out,
    output logic              Ovf,
    output logic              Seq_Err
);

    logic [0:0]        state_q;
    logic              carry_q;
    logic              sub_q;
    logic [IDX_W-1:0]  cnt_q;

    logic              accept;
    logic              as_first;
    logic              sub_eff;
    logic              c0;
    logic              csa_cout;
    logic              force_last;
    logic              last_eff;
    logic              err;
    logic [WORD_W-1:0] b_eff;
    logic [WORD_W-1:0] sum;
    logic [IDX_W-1:0]  idx_next;

    assign In_Ready = !Out_Valid || Out_Ready;
    assign accept   = In_Valid && In_Ready;

    // A limb arriving in IDLE starts a sequence even without In_First.
    assign as_first = In_First || (state_q == ST_IDLE);
    assign sub_eff  = as_first ? Sub : sub_q;
    assign b_eff    = sub_eff ? ~B : B;
    assign c0       = as_first ? (Cin ^ Sub) : carry_q;

    assign idx_next   = as_first ? '0 : cnt_q + 1'b1;
    assign force_last = !In_Last && (idx_next == IDX_W'(MAX_LIMBS - 1));
    assign last_eff   = In_Last || force_last;
    assign err        = (In_First && (state_q == ST_RUN))
                     || (!In_First && (state_q == ST_IDLE))
                     || force_last;

    SixtyFourBitCSA_Standard u_csa (
        .A     (A),
        .B     (b_eff),
        .C0    (c0),
        .S     (sum),
        .C_Out (csa_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            carry_q   <= 1'b0;
            sub_q     <= 1'b0;
            cnt_q     <= '0;
            Out_Valid <= 1'b0;
            S         <= '0;
            Out_Last  <= 1'b0;
            Out_Index <= '0;
            C_Out     <= 1'b0;
            Ovf       <= 1'b0;
            Seq_Err   <= 1'b0;
        end else begin
            Seq_Err <= accept && err;
            if (accept) begin
                state_q   <= last_eff ? ST_IDLE : ST_RUN;
                cnt_q     <= idx_next;
                carry_q   <= csa_cout;
                if (as_first)
                    sub_q <= Sub;
                Out_Valid <= 1'b1;
                S         <= sum;
                Out_Last  <= last_eff;
                Out_Index <= idx_next;
                C_Out     <= csa_cout;
                Ovf       <= add_ovf(A[WORD_W-1], b_eff[WORD_W-1], sum[WORD_W-1]);
            end else if (Out_Ready) begin
                Out_Valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_multiword_csa_sequencer.sv
// Self-checking bench: wide add/sub reference computed with plain big-integer
// arithmetic, outputs captured on every handshake and compared per scenario.
module tb_multiword_csa_sequencer;

    localparam int IDX_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             In_Valid = 1'b0;
    logic             In_Ready;
    logic             In_First = 1'b0;
    logic             In_Last = 1'b0;
    logic             Sub = 1'b0;
    logic             Cin = 1'b0;
    logic [63:0]      A = '0;
    logic [63:0]      B = '0;
    logic             Out_Valid;
    logic             Out_Ready = 1'b1;
    logic [63:0]      S;
    logic             Out_Last;
    logic [IDX_W-1:0] Out_Index;
    logic             C_Out;
    logic             Ovf;
    logic             Seq_Err;

    typedef struct {
        logic [63:0]      s;
        logic             last;
        logic [IDX_W-1:0] idx;
        logic             cout;
        logic             ovf;
    } obs_t;

    obs_t        q[$];
    int          err_cnt = 0;
    int          checks = 0;
    int          failures = 0;
    int          q_base;
    int          e_base;
    int          bp_mode = 0;
    logic [63:0] ta[18];
    logic [63:0] tbv[18];
    logic [63:0] m_s[17];
    logic        m_cout;
    logic        m_ovf;

    multiword_csa_sequencer dut (
        .clk(clk), .rst(rst), .In_Valid(In_Valid), .In_Ready(In_Ready),
        .In_First(In_First), .In_Last(In_Last), .Sub(Sub), .Cin(Cin),
        .A(A), .B(B), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .S(S),
        .Out_Last(Out_Last), .Out_Index(Out_Index), .C_Out(C_Out), .Ovf(Ovf),
        .Seq_Err(Seq_Err)
    );

    always #5 clk = ~clk;

    // 0: always ready, 1: random stalls, 2: held off
    always @(posedge clk) begin
        #1;
        case (bp_mode)
            0:       Out_Ready = 1'b1;
            1:       Out_Ready = ($urandom_range(0, 2) != 0);
            default: Out_Ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (!rst && Out_Valid && Out_Ready)
            q.push_back('{S, Out_Last, Out_Index, C_Out, Ovf});
        if (Seq_Err)
            err_cnt++;
    end

    // Reference: whole-number add/sub over n*64 bits.
    function automatic void model(input int off, input int n, input logic sub, input logic cin);
        logic [1087:0] aw, bw, r;
        int w;
        logic sa, sb, sr;
        w  = n * 64;
        aw = '0;
        bw = '0;
        for (int i = 0; i < n; i++) begin
            aw[i*64 +: 64] = ta[off+i];
            bw[i*64 +: 64] = tbv[off+i];
        end
        if (!sub) begin
            r = aw + bw + 1088'(cin);
            m_cout = r[w];
        end else begin
            r = aw - bw - 1088'(cin);
            m_cout = (aw >= bw + 1088'(cin));
        end
        for (int i = 0; i < n; i++)
            m_s[i] = r[i*64 +: 64];
        sa = aw[w-1];
        sb = bw[w-1];
        sr = r[w-1];
        m_ovf = sub ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_limb(input logic f, input logic l, input logic sb, input logic ci,
                             input logic [63:0] a, input logic [63:0] b);
        bit ok = 0;
        In_Valid = 1'b1; In_First = f; In_Last = l; Sub = sb; Cin = ci; A = a; B = b;
        for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            if (In_Ready) begin ok = 1; break; end
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL accept_timeout In_Ready stuck at 0");
        end
        @(posedge clk);
        #1;
        In_Valid = 1'b0;
    endtask

    task automatic send_seq(input int off, input int n, input logic sub, input logic cin);
        for (int i = 0; i < n; i++)
            send_limb(i == 0, i == n - 1, sub, cin, ta[off+i], tbv[off+i]);
    endtask

    task automatic drain(input int n);
        int t = 0;
        while (q.size() < q_base + n && t < 3000) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != q_base + n) begin
            failures++;
            $display("FAIL drain_count got=%0d exp=%0d", q.size() - q_base, n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle(3);
        rst = 1'b0;
        idle(1);
        bp_mode = 2;
        idle(2);
        send_limb(1'b0, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks += 8;
        if (Out_Valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", Out_Valid); end
        if (S !== 64'd0)        begin failures++; $display("FAIL reset_s got=%h exp=0", S); end
        if (Out_Last !== 1'b0)  begin failures++; $display("FAIL reset_out_last got=%b exp=0", Out_Last); end
        if (Out_Index !== 4'd0) begin failures++; $display("FAIL reset_out_index got=%0d exp=0", Out_Index); end
        if (C_Out !== 1'b0)     begin failures++; $display("FAIL reset_c_out got=%b exp=0", C_Out); end
        if (Ovf !== 1'b0)       begin failures++; $display("FAIL reset_ovf got=%b exp=0", Ovf); end
        if (Seq_Err !== 1'b0)   begin failures++; $display("FAIL reset_seq_err got=%b exp=0", Seq_Err); end
        if (In_Ready !== 1'b1)  begin failures++; $display("FAIL reset_in_ready got=%b exp=1", In_Ready); end
        bp_mode = 0;
        idle(2);
    endtask

    task automatic test_directed();
        e_base = err_cnt;
        // single-limb add with carry out
        ta[0] = 64'hFFFF_FFFF_FFFF_FFFF; tbv[0] = 64'd1;
        q_base = q.size();
        send_seq(0, 1, 1'b0, 1'b0);
        drain(1);
        checks += 5;
        if (q[q_base].s !== 64'd0)   begin failures++; $display("FAIL single_add_s got=%h exp=0", q[q_base].s); end
        if (q[q_base].cout !== 1'b1) begin failures++; $display("FAIL single_add_cout got=%b exp=1", q[q_base].cout); end
        if (q[q_base].ovf !== 1'b0)  begin failures++; $display("FAIL single_add_ovf got=%b exp=0", q[q_base].ovf); end
        if (q[q_base].idx !== 4'd0)  begin failures++; $display("FAIL single_add_idx got=%0d exp=0", q[q_base].idx); end
        if (q[q_base].last !== 1'b1) begin failures++; $display("FAIL single_add_last got=%b exp=1", q[q_base].last); end

        // carry crossing limb boundary
        ta[0] = 64'hFFFF_FFFF_FFFF_FFFF; tbv[0] = 64'd1; ta[1] = 64'd0; tbv[1] = 64'd0;
        q_base = q.size();
        send_seq(0, 2, 1'b0, 1'b0);
        drain(2);
        checks += 5;
        if (q[q_base].s !== 64'd0)     begin failures++; $display("FAIL chain_s0 got=%h exp=0", q[q_base].s); end
        if (q[q_base+1].s !== 64'd1)   begin failures++; $display("FAIL chain_s1 got=%h exp=1", q[q_base+1].s); end
        if (q[q_base].last !== 1'b0)   begin failures++; $display("FAIL chain_last0 got=%b exp=0", q[q_base].last); end
        if (q[q_base+1].last !== 1'b1) begin failures++; $display("FAIL chain_last1 got=%b exp=1", q[q_base+1].last); end
        if (q[q_base+1].cout !== 1'b0) begin failures++; $display("FAIL chain_cout got=%b exp=0", q[q_base+1].cout); end

        // 128-bit subtract with borrow across limbs
        ta[0] = 64'd0; ta[1] = 64'd1; tbv[0] = 64'd1; tbv[1] = 64'd0;
        q_base = q.size();
        send_seq(0, 2, 1'b1, 1'b0);
        drain(2);
        checks += 3;
        if (q[q_base].s !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL sub128_s0 got=%h exp=ffffffffffffffff", q[q_base].s); end
        if (q[q_base+1].s !== 64'd0)   begin failures++; $display("FAIL sub128_s1 got=%h exp=0", q[q_base+1].s); end
        if (q[q_base+1].cout !== 1'b1) begin failures++; $display("FAIL sub128_cout got=%b exp=1", q[q_base+1].cout); end

        // signed overflow
        ta[0] = 64'h7FFF_FFFF_FFFF_FFFF; tbv[0] = 64'd1;
        q_base = q.size();
        send_seq(0, 1, 1'b0, 1'b0);
        drain(1);
        checks += 2;
        if (q[q_base].s !== 64'h8000_0000_0000_0000) begin failures++; $display("FAIL ovf_s got=%h exp=8000000000000000", q[q_base].s); end
        if (q[q_base].ovf !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", q[q_base].ovf); end

        checks++;
        if (err_cnt != e_base) begin failures++; $display("FAIL directed_seq_err got=%0d exp=0", err_cnt - e_base); end
    endtask

    task automatic test_random();
        e_base = err_cnt;
        bp_mode = 1;
        for (int r = 0; r < 25; r++) begin
            int   n;
            logic sub, cin;
            n   = $urandom_range(1, 16);
            sub = 1'($urandom);
            cin = 1'($urandom);
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 5))
                    0:       begin ta[i] = '1; tbv[i] = '0; end
                    1:       begin ta[i] = '0; tbv[i] = '1; end
                    default: begin ta[i] = {$urandom, $urandom}; tbv[i] = {$urandom, $urandom}; end
                endcase
            end
            model(0, n, sub, cin);
            q_base = q.size();
            send_seq(0, n, sub, cin);
            drain(n);
            for (int i = 0; i < n; i++) begin
                checks += 3;
                if (q[q_base+i].s !== m_s[i]) begin failures++; $display("FAIL rand_s seq=%0d limb=%0d got=%h exp=%h", r, i, q[q_base+i].s, m_s[i]); end
                if (q[q_base+i].idx !== 4'(i)) begin failures++; $display("FAIL rand_idx seq=%0d limb=%0d got=%0d exp=%0d", r, i, q[q_base+i].idx, i); end
                if (q[q_base+i].last !== (i == n - 1)) begin failures++; $display("FAIL rand_last seq=%0d limb=%0d got=%b", r, i, q[q_base+i].last); end
            end
            checks += 2;
            if (q[q_base+n-1].cout !== m_cout) begin failures++; $display("FAIL rand_cout seq=%0d got=%b exp=%b", r, q[q_base+n-1].cout, m_cout); end
            if (q[q_base+n-1].ovf !== m_ovf)   begin failures++; $display("FAIL rand_ovf seq=%0d got=%b exp=%b", r, q[q_base+n-1].ovf, m_ovf); end
        end
        checks++;
        if (err_cnt != e_base) begin failures++; $display("FAIL rand_seq_err got=%0d exp=0", err_cnt - e_base); end
        bp_mode = 0;
        idle(2);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 3; i++) begin ta[i] = {$urandom, $urandom}; tbv[i] = {$urandom, $urandom}; end
        ta[0] = '1;
        tbv[0] = 64'd5;
        model(0, 3, 1'b0, 1'b1);
        bp_mode = 2;
        idle(2);
        q_base = q.size();
        send_limb(1'b1, 1'b0, 1'b0, 1'b1, ta[0], tbv[0]);
        In_Valid = 1'b1; In_First = 1'b0; In_Last = 1'b0; A = ta[1]; B = tbv[1];
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks += 3;
            if (In_Ready !== 1'b0)  begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", k, In_Ready); end
            if (Out_Valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid cyc=%0d got=%b exp=1", k, Out_Valid); end
            if (S !== m_s[0])       begin failures++; $display("FAIL bp_s_hold cyc=%0d got=%h exp=%h", k, S, m_s[0]); end
        end
        @(posedge clk);
        #1;
        bp_mode = 0;
        send_limb(1'b0, 1'b0, 1'b0, 1'b0, ta[1], tbv[1]);
        send_limb(1'b0, 1'b1, 1'b0, 1'b0, ta[2], tbv[2]);
        drain(3);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (q[q_base+i].s !== m_s[i]) begin failures++; $display("FAIL bp_s limb=%0d got=%h exp=%h", i, q[q_base+i].s, m_s[i]); end
        end
        checks++;
        if (q[q_base+2].cout !== m_cout) begin failures++; $display("FAIL bp_cout got=%b exp=%b", q[q_base+2].cout, m_cout); end
    endtask

    task automatic test_errors();
        logic sub, cin;
        int   eid[4] = '{0, 1, 0, 1};

        // (a) restart mid-sequence; the trailing limb passes Sub=0 but must keep Sub=1
        for (int i = 0; i < 4; i++) begin ta[i] = {$urandom, $urandom}; tbv[i] = {$urandom, $urandom}; end
        model(2, 2, 1'b1, 1'b0);
        q_base = q.size();
        e_base = err_cnt;
        send_limb(1'b1, 1'b0, 1'b0, 1'b0, ta[0], tbv[0]);
        send_limb(1'b0, 1'b0, 1'b0, 1'b0, ta[1], tbv[1]);
        send_limb(1'b1, 1'b0, 1'b1, 1'b0, ta[2], tbv[2]);
        send_limb(1'b0, 1'b1, 1'b0, 1'b0, ta[3], tbv[3]);
        drain(4);
        for (int i = 0; i < 4; i++) begin
            checks += 2;
            if (q[q_base+i].idx !== 4'(eid[i])) begin failures++; $display("FAIL restart_idx limb=%0d got=%0d exp=%0d", i, q[q_base+i].idx, eid[i]); end
            if (q[q_base+i].last !== (i == 3))  begin failures++; $display("FAIL restart_last limb=%0d got=%b", i, q[q_base+i].last); end
        end
        checks += 4;
        if (q[q_base+2].s !== m_s[0])    begin failures++; $display("FAIL restart_s0 got=%h exp=%h", q[q_base+2].s, m_s[0]); end
        if (q[q_base+3].s !== m_s[1])    begin failures++; $display("FAIL restart_s1 got=%h exp=%h", q[q_base+3].s, m_s[1]); end
        if (q[q_base+3].cout !== m_cout) begin failures++; $display("FAIL restart_cout got=%b exp=%b", q[q_base+3].cout, m_cout); end
        if (err_cnt - e_base != 1)       begin failures++; $display("FAIL restart_seq_err got=%0d exp=1", err_cnt - e_base); end

        // (b) 17 limbs with no Last, then a closing limb
        sub = 1'($urandom);
        cin = 1'($urandom);
        for (int i = 0; i < 18; i++) begin ta[i] = {$urandom, $urandom}; tbv[i] = {$urandom, $urandom}; end
        q_base = q.size();
        e_base = err_cnt;
        for (int i = 0; i < 17; i++)
            send_limb(i == 0, 1'b0, sub, cin, ta[i], tbv[i]);
        send_limb(1'b0, 1'b1, sub, cin, ta[17], tbv[17]);
        drain(18);
        model(0, 16, sub, cin);
        for (int i = 0; i < 16; i++) begin
            checks += 3;
            if (q[q_base+i].s !== m_s[i])        begin failures++; $display("FAIL cap_s limb=%0d got=%h exp=%h", i, q[q_base+i].s, m_s[i]); end
            if (q[q_base+i].idx !== 4'(i))       begin failures++; $display("FAIL cap_idx limb=%0d got=%0d exp=%0d", i, q[q_base+i].idx, i); end
            if (q[q_base+i].last !== (i == 15))  begin failures++; $display("FAIL cap_last limb=%0d got=%b", i, q[q_base+i].last); end
        end
        checks++;
        if (q[q_base+15].cout !== m_cout) begin failures++; $display("FAIL cap_cout got=%b exp=%b", q[q_base+15].cout, m_cout); end
        model(16, 2, sub, cin);
        for (int i = 0; i < 2; i++) begin
            checks += 3;
            if (q[q_base+16+i].s !== m_s[i])      begin failures++; $display("FAIL cap_tail_s limb=%0d got=%h exp=%h", i, q[q_base+16+i].s, m_s[i]); end
            if (q[q_base+16+i].idx !== 4'(i))     begin failures++; $display("FAIL cap_tail_idx limb=%0d got=%0d exp=%0d", i, q[q_base+16+i].idx, i); end
            if (q[q_base+16+i].last !== (i == 1)) begin failures++; $display("FAIL cap_tail_last limb=%0d got=%b", i, q[q_base+16+i].last); end
        end
        checks++;
        if (err_cnt - e_base != 2) begin failures++; $display("FAIL cap_seq_err got=%0d exp=2", err_cnt - e_base); end

        // (c) reset during RUN drops the partial sequence
        bp_mode = 2;
        idle(2);
        q_base = q.size();
        send_limb(1'b1, 1'b0, 1'b0, 1'b0, 64'd11, 64'd22);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks += 2;
        if (Out_Valid !== 1'b0) begin failures++; $display("FAIL rst_run_out_valid got=%b exp=0", Out_Valid); end
        if (In_Ready !== 1'b1)  begin failures++; $display("FAIL rst_run_in_ready got=%b exp=1", In_Ready); end
        @(posedge clk);
        #1;
        bp_mode = 0;
        idle(2);
        ta[0] = {$urandom, $urandom}; tbv[0] = {$urandom, $urandom};
        ta[1] = {$urandom, $urandom}; tbv[1] = {$urandom, $urandom};
        model(0, 2, 1'b1, 1'b1);
        e_base = err_cnt;
        send_seq(0, 2, 1'b1, 1'b1);
        drain(2);
        checks += 5;
        if (q[q_base].idx !== 4'd0)      begin failures++; $display("FAIL rst_run_idx0 got=%0d exp=0", q[q_base].idx); end
        if (q[q_base+1].idx !== 4'd1)    begin failures++; $display("FAIL rst_run_idx1 got=%0d exp=1", q[q_base+1].idx); end
        if (q[q_base].s !== m_s[0])      begin failures++; $display("FAIL rst_run_s0 got=%h exp=%h", q[q_base].s, m_s[0]); end
        if (q[q_base+1].s !== m_s[1])    begin failures++; $display("FAIL rst_run_s1 got=%h exp=%h", q[q_base+1].s, m_s[1]); end
        if (err_cnt != e_base)           begin failures++; $display("FAIL rst_run_seq_err got=%0d exp=0", err_cnt - e_base); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_errors();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
